bcd_display_scan: RTL and testbench



---
 rtl/bcd_display_pkg.sv | 41 ++++
 rtl/bcd_to_seg.sv | 11 +
 rtl/bcd_display_scan.sv | 160 ++++++++++++++++
 tb/tb_bcd_display_scan.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared types, seven-segment patterns and the BCD decode function for the display scanner.
package bcd_display_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    // Segment order g,f,e,d,c,b,a (bit 6 .. bit 0), active-high
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; invalid codes show a dash.
module bcd_to_seg
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    assign seg_c = seg_decode(bcd);

endmodule

// File: rtl/bcd_display_scan.sv
// Frame-captured multiplexed seven-segment scanner with anti-ghosting blank gap.
// Optional leading-zero suppression when LEADING_ZERO_BLANK_EN is defined.
module bcd_display_scan
    import bcd_display_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                  inpulse,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int unsigned IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned SHOW_LAST  = SCAN_DIV - BLANK_CYCLES - 1;
    localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam int unsigned IDX_LAST   = DIGITS - 1;

    state_t               state, state_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 load_en;
    logic                 advance;
    logic [3:0]           shadow_bcd [DIGITS];
    logic [DIGITS-1:0]    shadow_dp;
    logic [3:0]           digit_c;
    logic [6:0]           digit_seg_c;
    logic                 digit_blank_c;
    logic [6:0]           seg_next;
    logic                 dp_next;
    logic [DIGITS-1:0]    an_next;
    logic                 frame_done_next;

    assign digit_c = shadow_bcd[idx];

    bcd_to_seg u_bcd_to_seg (
        .bcd   (digit_c),
        .seg_c (digit_seg_c)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_mask, blank_mask_load;
    logic              zero_run;

    // A digit stays blank while it and everything above it is zero with no decimal point.
    always_comb begin
        blank_mask_load = '0;
        zero_run        = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run           = zero_run & (bcd_in[4*k +: 4] == 4'd0) & ~dp_in[k];
            blank_mask_load[k] = zero_run;
        end
    end

    always_ff @(posedge inpulse) begin
        if (load_en) begin
            blank_mask <= blank_mask_load;
        end
    end

    assign digit_blank_c = blank_mask[idx];
`else
    assign digit_blank_c = 1'b0;
`endif

    // Shadow capture once per frame so counter ripple never tears a frame.
    always_ff @(posedge inpulse) begin
        if (load_en) begin
            for (int k = 0; k < int'(DIGITS); k++) begin
                shadow_bcd[k] <= bcd_in[4*k +: 4];
            end
            shadow_dp <= dp_in;
        end
    end

    always_ff @(posedge inpulse) begin
        if (!rst) begin
            state      <= LOAD;
            idx        <= '0;
            cnt        <= '0;
            seg        <= '0;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            cnt        <= cnt_next;
            seg        <= seg_next;
            dp         <= dp_next;
            an         <= an_next;
            frame_done <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state;
        idx_next        = idx;
        cnt_next        = cnt + CNT_W'(1);
        load_en         = 1'b0;
        advance         = 1'b0;
        seg_next        = '0;
        dp_next         = 1'b0;
        an_next         = '0;
        frame_done_next = 1'b0;

        case (state)
            LOAD: begin
                load_en         = 1'b1;
                frame_done_next = 1'b1;
                idx_next        = '0;
                cnt_next        = '0;
                state_next      = SHOW;
            end
            SHOW: begin
                an_next = DIGITS'(1) << idx;
                if (!digit_blank_c) begin
                    seg_next = digit_seg_c;
                    dp_next  = shadow_dp[idx];
                end
                if (cnt == CNT_W'(SHOW_LAST)) begin
                    cnt_next = '0;
                    if (BLANK_CYCLES > 0) begin
                        state_next = BLANK;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            BLANK: begin
                if (cnt == CNT_W'(BLANK_LAST)) begin
                    cnt_next = '0;
                    advance  = 1'b1;
                end
            end
            default: begin
                state_next = LOAD;
                cnt_next   = '0;
            end
        endcase

        // End of a digit slot: move to the next digit or start a new frame.
        if (advance) begin
            if (idx == IDX_W'(IDX_LAST)) begin
                state_next = LOAD;
            end else begin
                idx_next   = idx + IDX_W'(1);
                state_next = SHOW;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: expected per-cycle outputs are queued with
// their cycle stamp and a negedge monitor pops and compares them.
module tb_bcd_display_scan;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned SCAN_DIV  = 8;
    localparam int unsigned BLANK_CYC = 2;
    localparam int          SHOW_LEN  = 6;
    localparam int          FRAME_LEN = 33;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
        7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000
    };

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] MASK_00A5 = 4'b1100;
    localparam logic [3:0] MASK_0000 = 4'b1000;
`else
    localparam logic [3:0] MASK_00A5 = 4'b0000;
    localparam logic [3:0] MASK_0000 = 4'b0000;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    bcd_display_scan #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYC)
    ) dut (
        .inpulse    (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_zero(input int c);
        exp_t e;
        e.cyc = c; e.an = '0; e.seg = '0; e.dp = 1'b0; e.fd = 1'b0;
        q.push_back(e);
    endtask

    // Queue the outputs of a frame whose LOAD output appears at cycle start.
    task automatic push_frame(input int start, input logic [15:0] b, input logic [3:0] d,
                              input logic [3:0] blk, input int len);
        exp_t e;
        int   k;
        int   s;
        for (int o = 0; o < len; o++) begin
            e.cyc = start + o; e.an = '0; e.seg = '0; e.dp = 1'b0; e.fd = (o == 0);
            if (o > 0) begin
                k = (o - 1) / int'(SCAN_DIV);
                s = (o - 1) % int'(SCAN_DIV);
                if (s < SHOW_LEN) begin
                    e.an = 4'(1 << k);
                    if (!blk[k]) begin
                        e.seg = SEG_TBL[b[4*k +: 4]];
                        e.dp  = d[k];
                    end
                end
            end
            q.push_back(e);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        n_cmp++;
        if ($countones(an) > 1) begin
            n_err++;
            $display("FAIL onehot cyc=%0d an=%b required one-hot or zero", cyc, an);
        end
        if (frame_done) begin
            n_cmp++;
            if (an != 4'b0000) begin
                n_err++;
                $display("FAIL load_an cyc=%0d an=%b required 0000", cyc, an);
            end
        end
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (e.cyc != cyc || an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
                n_err++;
                $display("FAIL out cyc=%0d(exp %0d) got an=%b seg=%b dp=%b fd=%b required an=%b seg=%b dp=%b fd=%b",
                         cyc, e.cyc, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
        end
    end

    initial begin
        int t;
        int f;
        int guard;
        rst    = 1'b0;
        bcd_in = 16'h1234;
        dp_in  = 4'b0000;

        @(negedge clk);
        expect_zero(cyc + 1);
        expect_zero(cyc + 2);
        @(negedge clk);
        @(negedge clk);

        // Release: frames A and B both capture 1234
        rst = 1'b1;
        t   = cyc;
        push_frame(t + 1, 16'h1234, 4'b0000, 4'b0000, FRAME_LEN);
        push_frame(t + 1 + FRAME_LEN, 16'h1234, 4'b0000, 4'b0000, FRAME_LEN);

        // Change input mid-SHOW of digit 1 in frame B; visible only from frame C
        wait_until(t + 1 + FRAME_LEN + 11);
        bcd_in = 16'h9999;
        push_frame(t + 1 + 2*FRAME_LEN, 16'h9999, 4'b0000, 4'b0000, FRAME_LEN);

        wait_until(t + 1 + 2*FRAME_LEN + 3);
        bcd_in = 16'h00A5;
        push_frame(t + 1 + 3*FRAME_LEN, 16'h00A5, 4'b0000, MASK_00A5, FRAME_LEN);

        wait_until(t + 1 + 3*FRAME_LEN + 3);
        bcd_in = 16'h0000;
        dp_in  = 4'b0100;
        push_frame(t + 1 + 4*FRAME_LEN, 16'h0000, 4'b0100, MASK_0000, FRAME_LEN);

        // Frame F is cut by a reset during the blank gap of digit 2
        wait_until(t + 1 + 4*FRAME_LEN + 3);
        bcd_in = 16'h1234;
        dp_in  = 4'b0001;
        f = t + 1 + 5*FRAME_LEN;
        push_frame(f, 16'h1234, 4'b0001, 4'b0000, 24);
        wait_until(f + 23);
        rst = 1'b0;
        expect_zero(f + 24);
        expect_zero(f + 25);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        push_frame(cyc + 1, 16'h1234, 4'b0001, 4'b0000, FRAME_LEN);

        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain %0d entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
